// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path behind the core's MMIO byte port.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [31:0] UART_MMIO_ADDR  = 32'h0000_fff0;
    localparam logic [31:0] UART_MMIO_FLAG  = 32'h0000_fff1;
    localparam int          UART_FRAME_BITS = 10;
    localparam int          UART_DATA_BITS  = UART_FRAME_BITS - 2;

    // Line level implied by a frame state; only DATA depends on the shifted byte.
    function automatic logic line_level(input uart_tx_state_t st, input logic data_bit);
        case (st)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte strobe in, serial line and status out; the slave side is the serializer.
interface uart_tx_serializer_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [8:0]       uart_in;
    logic             tx;
    logic             tx_ready;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output uart_in,
        input  tx, tx_ready, busy, overflow, fifo_count
    );

    modport slave (
        input  uart_in,
        output tx, tx_ready, busy, overflow, fifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty come from the occupancy count, pointers wrap freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers MMIO byte strobes and sends them as back-to-back 8N1 frames on a registered TX line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input logic                 clock,
    input logic                 reset_n,
    uart_tx_serializer_if.slave bus
);
    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t    state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              overflow_q, overflow_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              busy;

    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (bus.uart_in[8]),
        .wdata_i (bus.uart_in[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    baud_d  = BAUD_RELOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when another byte is waiting.
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        baud_d  = BAUD_RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX is precomputed from the next state so the pin comes straight off a flop.
    always_comb begin
        tx_d       = line_level(state_d, shreg_d[0]);
        overflow_d = overflow_q | (bus.uart_in[8] & fifo_full & ~pop);
        busy       = (state_q != IDLE) || (fifo_count != '0);
    end

    assign bus.tx         = tx_q;
    assign bus.tx_ready   = !fifo_full;
    assign bus.busy       = busy;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and randomized bench for uart_tx_serializer against a frame-schedule reference model.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_serializer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    // Reference model: each accepted byte is a frame with a push edge and a start edge.
    int         f_push[$];
    int         f_start[$];
    logic [7:0] f_data[$];
    bit         m_ovf;

    // Line receiver decoding whatever the DUT puts on tx.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         rx_busy;
    int         rx_t0;
    logic [7:0] rx_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count(input int t);
        int n = 0;
        foreach (f_push[i]) if (f_push[i] <= t && f_start[i] > t) n++;
        return n;
    endfunction

    function automatic bit m_active(input int t);
        foreach (f_start[i]) if (t >= f_start[i] && t < f_start[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(input int t);
        int k;
        logic [7:0] d;
        foreach (f_start[i]) begin
            if (t >= f_start[i] && t < f_start[i] + FRAME) begin
                k = (t - f_start[i]) / CPB;
                d = f_data[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return d[k-1];
            end
        end
        return 1'b1;
    endfunction

    task automatic model_push(input int t, input logic [7:0] b);
        int occ;
        bit popnow;
        int s;
        occ = 0;
        popnow = 1'b0;
        foreach (f_push[i]) begin
            if (f_push[i] < t && f_start[i] >= t) occ++;
            if (f_start[i] == t) popnow = 1'b1;
        end
        if (occ < DEPTH || popnow) begin
            s = t + 1;
            if (f_start.size() > 0 && f_start[$] + FRAME > s) s = f_start[$] + FRAME;
            f_push.push_back(t);
            f_start.push_back(s);
            f_data.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        f_push.delete();
        f_start.delete();
        f_data.delete();
        m_ovf = 1'b0;
        rx_busy = 1'b0;
        rx_q.delete();
    endtask

    task automatic check_outputs();
        int n;
        n = m_count(cyc);
        chk($sformatf("tx@%0d", cyc), 32'(bus.tx), 32'(m_tx(cyc)));
        chk($sformatf("fifo_count@%0d", cyc), 32'(bus.fifo_count), 32'(n));
        chk($sformatf("tx_ready@%0d", cyc), 32'(bus.tx_ready), 32'(n != DEPTH));
        chk($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'((n != 0) || m_active(cyc)));
        chk($sformatf("overflow@%0d", cyc), 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic rx_sample();
        int off;
        int k;
        if (rx_busy) begin
            off = cyc - rx_t0;
            if (off % CPB == CPB / 2) begin
                k = off / CPB;
                if (k >= 1 && k <= 8) begin
                    rx_byte[k-1] = bus.tx;
                end else if (k == 9) begin
                    chk($sformatf("stop_bit@%0d", cyc), 32'(bus.tx), 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end else if (bus.tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_t0 = cyc;
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
    task automatic tick(input logic stb, input logic [7:0] b);
        bus.uart_in = {stb, b};
        @(posedge clock);
        cyc++;
        if (stb) model_push(cyc, b);
        @(negedge clock);
        bus.uart_in = '0;
        check_outputs();
        rx_sample();
    endtask

    task automatic drain();
        int end_t;
        end_t = (f_start.size() > 0) ? f_start[$] + FRAME : cyc;
        while (cyc < end_t + 2) tick(1'b0, 8'h00);
        f_push.delete();
        f_start.delete();
        f_data.delete();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        rx_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.uart_in = '0;
        model_clear();
        repeat (2) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    endtask

    initial begin
        int target;
        int nbytes;
        int burst;
        bus.uart_in = '0;
        model_clear();
        do_reset();
        repeat (3) tick(1'b0, 8'h00);

        // Single byte 0x41.
        tick(1'b1, 8'h41);
        chk("single_idle_on_push_edge", 32'(bus.tx), 32'd1);
        tick(1'b0, 8'h00);
        chk("single_start_low", 32'(bus.tx), 32'd0);
        drain();
        chk("single_busy_after", 32'(bus.busy), 32'd0);
        exp_q = {8'h41};
        check_rx("single");

        // Back-to-back 0x55 then 0xAA.
        tick(1'b1, 8'h55);
        tick(1'b1, 8'hAA);
        drain();
        exp_q = {8'h55, 8'hAA};
        check_rx("b2b");

        // Six strobes into a depth-4 FIFO: the sixth is dropped.
        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        drain();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("ovf");
        do_reset();

        // Strobe into a full FIFO on the STOP->START pop edge.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i));
        target = f_start[1];
        while (cyc < target - 1) tick(1'b0, 8'h00);
        tick(1'b1, 8'h15);
        chk("fullpop_count", 32'(bus.fifo_count), 32'd4);
        chk("fullpop_overflow", 32'(bus.overflow), 32'd0);
        drain();
        exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_rx("fullpop");

        // Randomized bursts and gaps.
        nbytes = 0;
        while (nbytes < 30) begin
            repeat ($urandom_range(0, 50)) tick(1'b0, 8'h00);
            burst = $urandom_range(1, 6);
            for (int j = 0; j < burst; j++) tick(1'b1, 8'($urandom));
            nbytes += burst;
        end
        exp_q = f_data;
        drain();
        check_rx("random");
        do_reset();

        // Asynchronous reset during data bit 3 of the first of two queued frames.
        tick(1'b1, 8'hC3);
        tick(1'b1, 8'h3C);
        target = f_start[0] + 4 * CPB + 1;
        while (cyc < target) tick(1'b0, 8'h00);
        chk("midrst_bit3_before", 32'(bus.tx), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_tx_async", 32'(bus.tx), 32'd1);
        chk("midrst_count_async", 32'(bus.fifo_count), 32'd0);
        do_reset();
        repeat (60) tick(1'b0, 8'h00);
        exp_q.delete();
        check_rx("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
